wb4_to_pi1: RTL
===============

Name: wb4_to_pi1

Overview:
- Single-clock bridge: a pipelined Wishbone B4 slave port in front of a PerInt (PI1) master port.
- Lets Wishbone-only initiators (DMA engines, debug masters, third-party cores) reach PI1 peripherals and memory.
- Buffers accepted Wishbone requests in a small FIFO and issues them as PI1 ops in order.
- Returns exactly one wb4_ack_o per accepted request, carrying read data where applicable.

Parameters:
- ARCHBITSZ, 16: data width in bits; legal values 16, 32, 64, 128, 256.
- FIFODEPTHLOG2, 1: request FIFO depth is 2**FIFODEPTHLOG2 entries; legal range 1..4.

Ports:
- wb4_clk_i  in  1  sole clock; all logic on its rising edge.
- wb4_rst_ni  in  1  reset, asynchronous and active-low.
- wb4_cyc_i  in  1  WB4 cycle.
- wb4_stb_i  in  1  WB4 strobe.
- wb4_we_i  in  1  WB4 write enable.
- wb4_addr_i  in  ARCHBITSZ  WB4 byte address.
- wb4_data_i  in  ARCHBITSZ  WB4 write data.
- wb4_sel_i  in  ARCHBITSZ/8  WB4 byte selects.
- wb4_stall_o  out  1  WB4 stall.
- wb4_ack_o  out  1  WB4 acknowledge.
- wb4_data_o  out  ARCHBITSZ  WB4 read data.
- pi1_op_o  out  2  PI1 op: 00 NOOP, 01 WR, 10 RD, 11 RW.
- pi1_addr_o  out  ARCHBITSZ-clog2(ARCHBITSZ/8)  PI1 word address.
- pi1_data_o  out  ARCHBITSZ  PI1 write data.
- pi1_data_i  in  ARCHBITSZ  PI1 read data.
- pi1_sel_o  out  ARCHBITSZ/8  PI1 byte selects.
- pi1_rdy_i  in  1  PI1 ready.

Behaviour:
- Reset (wb4_rst_ni=0, asynchronous):
  - FIFO emptied, pending flag cleared.
  - wb4_ack_o=0, wb4_data_o=0, wb4_stall_o=1.
  - pi1_op_o=NOOP; pi1_addr_o, pi1_data_o and pi1_sel_o all 0.
  - Leaving reset: wb4_stall_o deasserts on the first clock edge.
- Accept: a request is pushed when wb4_cyc_i && wb4_stb_i && !wb4_stall_o.
  - Entry = {we, addr[ARCHBITSZ-1:clog2(ARCHBITSZ/8)], data, sel}; low address bits are dropped, sel carries the lane information.
  - wb4_stall_o = FIFO full. Full is evaluated before any pop in the same cycle, so a full FIFO stalls even on a cycle where it pops.
- Issue:
  - pi1_op_o/addr/data/sel are driven combinationally from the FIFO head when the FIFO is non-empty: op = WR if we, else RD. Otherwise op=NOOP and the other PI1 outputs are 0.
  - An op is accepted by the slave on any cycle where pi1_rdy_i=1 and pi1_op_o!=NOOP; the head is popped on that edge.
  - Ops must be held stable while pi1_rdy_i=0.
- Completion:
  - The result of an accepted op is sampled on the next cycle with pi1_rdy_i=1.
  - pending <= (op accepted this rdy cycle); it updates only on cycles with pi1_rdy_i=1.
  - On a rdy cycle with pending=1: register wb4_ack_o=1 for one cycle. wb4_data_o = pi1_data_i for reads, 0 for writes. Otherwise wb4_ack_o=0.
  - Back-to-back throughput is one op per rdy cycle.
  - Minimum latency, stb to ack: 3 cycles (push, issue/accept, result sample -> registered ack).
- Ordering: acks are returned strictly in request order. At most FIFO depth + 1 requests are outstanding.
- Abort: wb4_cyc_i=0 at a clock edge does three things:
  - flushes all un-issued FIFO entries;
  - marks the in-flight op (pending=1) as discarded: it still completes on PI1, but its ack is suppressed;
  - blocks pushes for that cycle.
- Simultaneous push and pop on a non-full FIFO: both happen and the count is unchanged.
- pi1_rdy_i=1 with an empty FIFO and pending=0: nothing happens.

Optional Feature:
- Macro: WB4_TO_PI1_RWOP_EN.
- With the macro defined:
  - adds port wb4_tga_i (in, 1), stored per FIFO entry;
  - a write with wb4_tga_i=1 is issued as op RW (11), an atomic swap;
  - its ack returns the old memory word on wb4_data_o.
- Without the macro: the port is absent, RW is never issued, and write acks always return 0.

Test Plan:
- ARCHBITSZ=32, pi1_rdy_i=1 constant. Write addr 0x104, data 0xDEADBEEF, sel 1111 -> pi1_op_o=01 with pi1_addr_o=0x41. Single ack 3 cycles after stb, wb4_data_o=0.
- Read addr 0x106, sel 1100 -> pi1_op_o=10, pi1_addr_o=0x41, pi1_sel_o=1100. Slave returns 0x12345678 -> ack with wb4_data_o=0x12345678.
- pi1_rdy_i held 0 while 3 requests are issued (FIFODEPTHLOG2=1) -> 2 accepted and the 3rd stalled (wb4_stall_o=1). Release rdy -> 3 acks in order, one per rdy cycle.
- Drop wb4_cyc_i with 1 in flight and 2 queued -> queued ops are never issued and no ack appears. Next cycle starts clean: a new read returns exactly one ack.
- Assert wb4_rst_ni=0 asynchronously mid-transfer -> pi1_op_o=00 and wb4_ack_o=0 immediately. After release, a read completes normally.
- WB4_TO_PI1_RWOP_EN, memory word 0xAAAA5555, write 0x0F0F0F0F with tga=1 -> pi1_op_o=11. Ack returns 0xAAAA5555; a following read returns 0x0F0F0F0F.

Source files
------------

// File: rtl/wb4_to_pi1.sv
// wb4_to_pi1: pipelined Wishbone B4 slave to PerInt (PI1) master bridge.
//
// Wishbone requests are queued in a small in-order FIFO. The FIFO head is
// presented on the PI1 port as an op. Each accepted op is completed on the
// next PI1 ready cycle with a single registered wb4_ack_o.
//
// Parameters:
//   ARCHBITSZ      data width (16/32/64/128/256)
//   FIFODEPTHLOG2  request FIFO depth is 2**FIFODEPTHLOG2 (1..4)
//
// Ports:
//   wb4_clk_i, wb4_rst_ni        clock, asynchronous active-low reset
//   wb4_cyc_i/stb_i/we_i         WB4 cycle, strobe, write enable
//   wb4_addr_i/data_i/sel_i      WB4 byte address, write data, byte selects
//   wb4_tga_i                    atomic-swap tag (only with WB4_TO_PI1_RWOP_EN)
//   wb4_stall_o/ack_o/data_o     WB4 stall, acknowledge, read data
//   pi1_op_o/addr_o/data_o/sel_o PI1 op, word address, write data, selects
//   pi1_data_i, pi1_rdy_i        PI1 read data, ready
//
// Optional feature macro: WB4_TO_PI1_RWOP_EN. When it is defined, a write
// tagged with wb4_tga_i=1 is issued as RW (atomic swap) and its ack returns
// the old memory word.
module wb4_to_pi1 #(
  parameter int ARCHBITSZ     = 16,
  parameter int FIFODEPTHLOG2 = 1
) (
  input  logic                                        wb4_clk_i,
  input  logic                                        wb4_rst_ni,
  input  logic                                        wb4_cyc_i,
  input  logic                                        wb4_stb_i,
  input  logic                                        wb4_we_i,
  input  logic [ARCHBITSZ-1:0]                        wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]                        wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]                      wb4_sel_i,
`ifdef WB4_TO_PI1_RWOP_EN
  input  logic                                        wb4_tga_i,
`endif
  output logic                                        wb4_stall_o,
  output logic                                        wb4_ack_o,
  output logic [ARCHBITSZ-1:0]                        wb4_data_o,
  output logic [1:0]                                  pi1_op_o,
  output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]    pi1_addr_o,
  output logic [ARCHBITSZ-1:0]                        pi1_data_o,
  input  logic [ARCHBITSZ-1:0]                        pi1_data_i,
  output logic [ARCHBITSZ/8-1:0]                      pi1_sel_o,
  input  logic                                        pi1_rdy_i
);

  localparam int SELW  = ARCHBITSZ / 8;
  localparam int LSB   = $clog2(SELW);
  localparam int AW    = ARCHBITSZ - LSB;
  localparam int PW    = FIFODEPTHLOG2;
  localparam int DEPTH = 2 ** FIFODEPTHLOG2;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    OP_NOOP = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } pi1_op_e;

  // FIFO storage (no reset needed: only entries below count are ever read)
  logic            fifo_we   [DEPTH];
  logic            fifo_tga  [DEPTH];
  logic [AW-1:0]   fifo_addr [DEPTH];
  logic [ARCHBITSZ-1:0] fifo_data [DEPTH];
  logic [SELW-1:0] fifo_sel  [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   count_reg, count_next;
  logic          started_reg;
  logic          pending_reg, pending_next;
  logic          discard_reg, discard_next;
  logic          pend_rd_reg, pend_rd_next;
  logic          ack_reg, ack_next;
  logic [ARCHBITSZ-1:0] rdata_reg, rdata_next;

  logic full, empty, push, accept;
  logic head_we, head_tga, head_rd;
  logic cur_tga;

  // The dropped byte-offset address bits are carried by the selects.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, wb4_addr_i[LSB-1:0]};

`ifdef WB4_TO_PI1_RWOP_EN
  assign cur_tga = wb4_tga_i;
`else
  assign cur_tga = 1'b0;
`endif

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  // Stall is held through reset and for the cycle until the first edge.
  assign wb4_stall_o = !started_reg || full;
  assign push   = wb4_cyc_i && wb4_stb_i && !wb4_stall_o;
  assign accept = pi1_rdy_i && !empty;

  assign head_we  = fifo_we[rd_ptr_reg];
  assign head_tga = fifo_tga[rd_ptr_reg];
  // Reads and swaps return the memory word; plain writes return zero.
  assign head_rd  = !head_we || head_tga;

  always_comb begin
    pi1_op_o   = OP_NOOP;
    pi1_addr_o = '0;
    pi1_data_o = '0;
    pi1_sel_o  = '0;
    if (!empty) begin
      if (head_we && head_tga) pi1_op_o = OP_RW;
      else if (head_we)        pi1_op_o = OP_WR;
      else                     pi1_op_o = OP_RD;
      pi1_addr_o = fifo_addr[rd_ptr_reg];
      pi1_data_o = fifo_data[rd_ptr_reg];
      pi1_sel_o  = fifo_sel[rd_ptr_reg];
    end
  end

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    pending_next = pending_reg;
    discard_next = discard_reg;
    pend_rd_next = pend_rd_reg;
    ack_next     = 1'b0;
    rdata_next   = '0;

    if (!wb4_cyc_i) begin
      // Abort: drop everything not yet issued.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push)   wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (accept) rd_ptr_next = rd_ptr_reg + PTR_ONE;
      case ({push, accept})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end

    if (pi1_rdy_i) begin
      // Result of the previously accepted op is sampled now. An abort on
      // this same edge also suppresses its ack.
      ack_next = pending_reg && !discard_reg && wb4_cyc_i;
      if (ack_next && pend_rd_reg) rdata_next = pi1_data_i;
      pending_next = accept;
      discard_next = !wb4_cyc_i;
      pend_rd_next = head_rd;
    end else if (!wb4_cyc_i) begin
      // In-flight op still completes on PI1 but must not be acked.
      discard_next = 1'b1;
    end
  end

  always_ff @(posedge wb4_clk_i or negedge wb4_rst_ni) begin
    if (!wb4_rst_ni) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      started_reg <= 1'b0;
      pending_reg <= 1'b0;
      discard_reg <= 1'b0;
      pend_rd_reg <= 1'b0;
      ack_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      started_reg <= 1'b1;
      pending_reg <= pending_next;
      discard_reg <= discard_next;
      pend_rd_reg <= pend_rd_next;
      ack_reg     <= ack_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_ff @(posedge wb4_clk_i) begin
    if (push) begin
      fifo_we[wr_ptr_reg]   <= wb4_we_i;
      fifo_tga[wr_ptr_reg]  <= cur_tga;
      fifo_addr[wr_ptr_reg] <= wb4_addr_i[ARCHBITSZ-1:LSB];
      fifo_data[wr_ptr_reg] <= wb4_data_i;
      fifo_sel[wr_ptr_reg]  <= wb4_sel_i;
    end
  end

  assign wb4_ack_o  = ack_reg;
  assign wb4_data_o = rdata_reg;

endmodule
